random_byte_packer: RTL

RANDOM_BYTE_PACKER -- requirements
Module: random_byte_packer

---
 rtl/random_byte_packer_if.sv | 25 ++
 rtl/random_byte_packer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/random_byte_packer_if.sv
// Bit-stream in / byte-stream out bundle for random_byte_packer.
// The slave modport is the packer's view; master is the driver/consumer side.
interface random_byte_packer_if #(
   parameter int DEPTH = 4
);
   logic                     clear;
   logic                     bit_valid;
   logic                     bit_in;
   logic                     byte_ready;
   logic                     byte_valid;
   logic [7:0]               byte_data;
   logic [$clog2(DEPTH):0]   level;
   logic                     overflow;
   logic [7:0]               drop_count;

   modport master (
      output clear, bit_valid, bit_in, byte_ready,
      input  byte_valid, byte_data, level, overflow, drop_count
   );

   modport slave (
      input  clear, bit_valid, bit_in, byte_ready,
      output byte_valid, byte_data, level, overflow, drop_count
   );
endinterface

// File: rtl/random_byte_packer.sv
// Packs a serial random bit stream into bytes (MSB first), optionally
// von Neumann debiased, and buffers them in a small FIFO with drop counting.
//
// Pair-phase FSM (only advances when DEBIAS=1):
//   state     | meaning
//   PH_FIRST  | waiting for the first bit of a debias pair
//   PH_SECOND | first bit held, next sampled bit completes the pair
module random_byte_packer #(
   parameter int DEPTH  = 4,
   parameter int DEBIAS = 0
) (
   input logic                 clk,
   input logic                 rst,
   random_byte_packer_if.slave bus
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);

   typedef enum logic {PH_FIRST = 1'b0, PH_SECOND = 1'b1} phase_t;

   phase_t          phase_q, phase_d;
   logic            first_q, first_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      drop_q, drop_d;
   logic [7:0]      mem_q [DEPTH];

   logic            acc_v, acc_b;
   logic            push, pop, full, wr_en, drop;
   logic [7:0]      push_data;

   // Pair-phase next state and accepted-bit extraction (01 -> 0, 10 -> 1).
   always_comb begin
      phase_d = phase_q;
      first_d = first_q;
      acc_v   = 1'b0;
      acc_b   = 1'b0;
      if (bus.bit_valid) begin
         if (DEBIAS != 0) begin
            case (phase_q)
               PH_FIRST: begin
                  phase_d = PH_SECOND;
                  first_d = bus.bit_in;
               end
               default: begin
                  phase_d = PH_FIRST;
                  acc_v   = first_q ^ bus.bit_in;
                  acc_b   = first_q;
               end
            endcase
         end else begin
            acc_v = 1'b1;
            acc_b = bus.bit_in;
         end
      end
      if (bus.clear) begin
         phase_d = PH_FIRST;
         first_d = 1'b0;
      end
   end

   // Byte assembly, FIFO bookkeeping and overflow accounting; clear wins.
   always_comb begin
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      level_d   = level_q;
      ovf_d     = ovf_q;
      drop_d    = drop_q;
      push_data = {shift_q[6:0], acc_b};
      push      = acc_v && (cnt_q == 3'd7);
      pop       = (level_q != '0) && bus.byte_ready;
      full      = (level_q == LW'(DEPTH));
      wr_en     = push && (!full || pop);
      drop      = push && full && !pop;
      if (acc_v) begin
         cnt_d   = cnt_q + 3'd1;
         shift_d = push_data;
      end
      if (wr_en) wptr_d = wptr_q + PW'(1);
      if (pop)   rptr_d = rptr_q + PW'(1);
      level_d = level_q + LW'(wr_en) - LW'(pop);
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
      if (bus.clear) begin
         cnt_d   = '0;
         shift_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
         ovf_d   = 1'b0;
         drop_d  = '0;
         wr_en   = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= PH_FIRST;
         first_q <= 1'b0;
         cnt_q   <= '0;
         shift_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         phase_q <= phase_d;
         first_q <= first_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   // FIFO storage; contents need no reset because the output is gated by level.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= push_data;
   end

   assign bus.byte_valid = (level_q != '0);
   assign bus.byte_data  = bus.byte_valid ? mem_q[rptr_q] : 8'h00;
   assign bus.level      = level_q;
   assign bus.overflow   = ovf_q;
   assign bus.drop_count = drop_q;
endmodule
